// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//   Parametrised synchronous modulo-N up/down counter. Every bit is clocked by
//   clk, so count is glitch-free and can be used directly as a bus value.
//   Features: enable, direction, parallel load with clamping, synchronous clear,
//   wrap or saturate at the range ends, cascade carry and a sticky overflow.
//
// Parameters
//   WIDTH     count register width, 1..32
//   MODULUS   count range is 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE  0 = wrap at range ends, 1 = hold at range ends
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-low reset
//   en         count enable, one step per clk while high
//   up_dn      1 = count up, 0 = count down
//   clr        synchronous clear of count and ovf (highest priority)
//   load       synchronous parallel load of load_val (clamped to MODULUS-1)
//   load_val   value taken on load
//   count      current count (registered)
//   tc         terminal count for the current direction (combinational)
//   carry_out  tc qualified by en and the absence of clr/load; drives the
//              en of the next stage in a cascade
//   ovf        sticky boundary flag, cleared only by clr or rst
// -----------------------------------------------------------------------------
module mod_updown_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry_out,
  output logic             ovf
);

  // Largest legal count value. When MODULUS == 2**WIDTH this is all ones and
  // the explicit wrap to zero below is the same as the natural adder overflow.
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             atMax, atZero;
  logic             loadTooBig;

  assign atMax  = (count_q == MAX_C);
  assign atZero = (count_q == '0);

  // Widened compare so the clamp also works when MODULUS is not a power of two
  // and never triggers when every WIDTH-bit value is already legal.
  assign loadTooBig = (64'(load_val) > (MODULUS - 64'd1));

  // tc and carry_out are deliberately unregistered so that every stage of a
  // cascade sees its enable before the same clock edge.
  assign tc        = up_dn ? atMax : atZero;
  assign carry_out = tc & en & ~clr & ~load;

  assign count = count_q;
  assign ovf   = ovf_q;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = loadTooBig ? MAX_C : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (atMax) begin
          // Both a wrap and a refused saturating step count as overflow.
          ovf_d   = 1'b1;
          count_d = SATURATE ? MAX_C : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (atZero) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? '0 : MAX_C;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_updown_counter
//   Self-checking bench for mod_updown_counter. Instances:
//     dutW  WIDTH=4, MODULUS=10, wrapping
//     dutS  WIDTH=4, MODULUS=10, saturating
//     dutD  default parameters (8 bits, modulus 256)
//     c0/c1 two wrapping decade stages cascaded through carry_out
//   Expected results are pushed to a scoreboard queue when inputs are driven
//   and popped when the registered output is sampled after the edge.
// -----------------------------------------------------------------------------
module tb_mod_updown_counter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int expCountQ[$];
  bit expOvfQ[$];

  // wrapping decade instance
  logic       wEn, wUp, wClr, wLoad, wTc, wCarry, wOvf;
  logic [3:0] wVal, wCount;
  // saturating decade instance
  logic       sEn, sUp, sClr, sLoad, sTc, sCarry, sOvf;
  logic [3:0] sVal, sCount;
  // default-parameter instance
  logic       dEn, dUp, dClr, dLoad, dTc, dCarry, dOvf;
  logic [7:0] dVal, dCount;
  // cascade pair
  logic       cEn, cUp, cClr, cLoad;
  logic [3:0] cVal, c0Count, c1Count;
  logic       c0Tc, c0Carry, c0Ovf, c1Tc, c1Carry, c1Ovf;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dutW (
    .clk(clk), .rst(rst), .en(wEn), .up_dn(wUp), .clr(wClr), .load(wLoad),
    .load_val(wVal), .count(wCount), .tc(wTc), .carry_out(wCarry), .ovf(wOvf));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dutS (
    .clk(clk), .rst(rst), .en(sEn), .up_dn(sUp), .clr(sClr), .load(sLoad),
    .load_val(sVal), .count(sCount), .tc(sTc), .carry_out(sCarry), .ovf(sOvf));

  mod_updown_counter dutD (
    .clk(clk), .rst(rst), .en(dEn), .up_dn(dUp), .clr(dClr), .load(dLoad),
    .load_val(dVal), .count(dCount), .tc(dTc), .carry_out(dCarry), .ovf(dOvf));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) c0 (
    .clk(clk), .rst(rst), .en(cEn), .up_dn(cUp), .clr(cClr), .load(cLoad),
    .load_val(cVal), .count(c0Count), .tc(c0Tc), .carry_out(c0Carry), .ovf(c0Ovf));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) c1 (
    .clk(clk), .rst(rst), .en(c0Carry), .up_dn(cUp), .clr(cClr), .load(cLoad),
    .load_val(cVal), .count(c1Count), .tc(c1Tc), .carry_out(c1Carry), .ovf(c1Ovf));

  // Async reset at time zero and mid-run with ovf set and count=0x5A.
  task automatic test_reset();
    int expC;
    bit expO;
    rst = 1'b0;
    {wEn, wUp, wClr, wLoad, wVal} = '0;
    {sEn, sUp, sClr, sLoad, sVal} = '0;
    {dEn, dUp, dClr, dLoad, dVal} = '0;
    {cEn, cUp, cClr, cLoad, cVal} = '0;
    #1;
    compared++;
    if ({wCount, sCount, dCount, c0Count, c1Count} !== 24'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_counts: got %h required 0", {wCount, sCount, dCount, c0Count, c1Count});
    end
    compared++;
    if ({wOvf, sOvf, dOvf, c0Ovf, c1Ovf} !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_ovf: got %b required 00000", {wOvf, sOvf, dOvf, c0Ovf, c1Ovf});
    end
    @(negedge clk) rst = 1'b1;

    // 0xFF, step up to 0 (sets ovf), then load 0x5A (ovf must survive load)
    @(negedge clk) begin dLoad = 1'b1; dVal = 8'hFF; end
    expCountQ.push_back(255); expOvfQ.push_back(1'b0);
    @(posedge clk) #1;
    expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
    compared++;
    if (dCount !== 8'(expC) || dOvf !== expO) begin
      mismatched++;
      $display("[TB] FAIL reset_load_ff: got %0d/%b required %0d/%b", dCount, dOvf, expC, expO);
    end
    @(negedge clk) begin dLoad = 1'b0; dEn = 1'b1; dUp = 1'b1; end
    expCountQ.push_back(0); expOvfQ.push_back(1'b1);
    @(posedge clk) #1;
    expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
    compared++;
    if (dCount !== 8'(expC) || dOvf !== expO) begin
      mismatched++;
      $display("[TB] FAIL reset_wrap_ff: got %0d/%b required %0d/%b", dCount, dOvf, expC, expO);
    end
    @(negedge clk) begin dEn = 1'b0; dLoad = 1'b1; dVal = 8'h5A; end
    expCountQ.push_back(8'h5A); expOvfQ.push_back(1'b1);
    @(posedge clk) #1;
    expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
    compared++;
    if (dCount !== 8'(expC) || dOvf !== expO) begin
      mismatched++;
      $display("[TB] FAIL reset_load_5a: got %0d/%b required %0d/%b", dCount, dOvf, expC, expO);
    end
    // load still pending; reset between edges must discard it
    dVal = 8'h33;
    rst  = 1'b0;
    #1;
    compared++;
    if (dCount !== 8'd0 || dOvf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_midrun: got %0d/%b required 0/0", dCount, dOvf);
    end
    dLoad = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  // 12 up steps on the wrapping decade counter.
  task automatic test_wrap_up();
    int cur = 0;
    bit ovfM = 1'b0;
    int expC;
    bit expO;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk) begin wEn = 1'b1; wUp = 1'b1; end
      #1;
      compared++;
      if (wTc !== (cur == 9) || wCarry !== (cur == 9)) begin
        mismatched++;
        $display("[TB] FAIL wrap_tc_carry at %0d: got %b/%b required %b/%b", cur, wTc, wCarry, cur == 9, cur == 9);
      end
      if (cur == 9) ovfM = 1'b1;
      cur = (cur + 1) % 10;
      expCountQ.push_back(cur); expOvfQ.push_back(ovfM);
      @(posedge clk) #1;
      expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
      compared++;
      if (wCount !== 4'(expC) || wOvf !== expO) begin
        mismatched++;
        $display("[TB] FAIL wrap_step %0d: got %0d/%b required %0d/%b", i, wCount, wOvf, expC, expO);
      end
    end
    @(negedge clk) wEn = 1'b0;
  endtask

  // Load 2, then count down into the saturating floor.
  task automatic test_down_saturate();
    int cur;
    bit ovfM = 1'b0;
    int expC;
    bit expO;
    @(negedge clk) begin sLoad = 1'b1; sVal = 4'd2; end
    expCountQ.push_back(2); expOvfQ.push_back(1'b0);
    @(posedge clk) #1;
    expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
    compared++;
    if (sCount !== 4'(expC) || sOvf !== expO) begin
      mismatched++;
      $display("[TB] FAIL sat_load: got %0d/%b required %0d/%b", sCount, sOvf, expC, expO);
    end
    cur = 2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) begin sLoad = 1'b0; sEn = 1'b1; sUp = 1'b0; end
      #1;
      compared++;
      if (sTc !== (cur == 0)) begin
        mismatched++;
        $display("[TB] FAIL sat_tc at %0d: got %b required %b", cur, sTc, cur == 0);
      end
      if (cur == 0) ovfM = 1'b1;
      else cur = cur - 1;
      expCountQ.push_back(cur); expOvfQ.push_back(ovfM);
      @(posedge clk) #1;
      expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
      compared++;
      if (sCount !== 4'(expC) || sOvf !== expO) begin
        mismatched++;
        $display("[TB] FAIL sat_down %0d: got %0d/%b required %0d/%b", i, sCount, sOvf, expC, expO);
      end
    end
    @(negedge clk) sEn = 1'b0;
  endtask

  // Clamp on load, carry gating by load, clr beating load. dutW holds ovf=1 here.
  task automatic test_load_clamp();
    int expC;
    bit expO;
    @(negedge clk) begin wLoad = 1'b1; wVal = 4'd15; end
    expCountQ.push_back(9); expOvfQ.push_back(1'b1);
    @(posedge clk) #1;
    expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
    compared++;
    if (wCount !== 4'(expC) || wOvf !== expO) begin
      mismatched++;
      $display("[TB] FAIL load_clamp: got %0d/%b required %0d/%b", wCount, wOvf, expC, expO);
    end
    @(negedge clk) begin wLoad = 1'b1; wVal = 4'd9; wEn = 1'b1; wUp = 1'b1; end
    #1;
    compared++;
    if (wTc !== 1'b1 || wCarry !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_blocks_carry: got tc/carry %b/%b required 1/0", wTc, wCarry);
    end
    expCountQ.push_back(9); expOvfQ.push_back(1'b1);
    @(posedge clk) #1;
    expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
    compared++;
    if (wCount !== 4'(expC) || wOvf !== expO) begin
      mismatched++;
      $display("[TB] FAIL load_over_en: got %0d/%b required %0d/%b", wCount, wOvf, expC, expO);
    end
    @(negedge clk) begin wClr = 1'b1; wLoad = 1'b0; end
    #1;
    compared++;
    if (wCarry !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL clr_blocks_carry: got %b required 0", wCarry);
    end
    wLoad = 1'b1; wVal = 4'd5;
    expCountQ.push_back(0); expOvfQ.push_back(1'b0);
    @(posedge clk) #1;
    expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
    compared++;
    if (wCount !== 4'(expC) || wOvf !== expO) begin
      mismatched++;
      $display("[TB] FAIL clr_over_load: got %0d/%b required %0d/%b", wCount, wOvf, expC, expO);
    end
    @(negedge clk) {wEn, wClr, wLoad} = '0;
  endtask

  // Two decade stages read as 00..99: every edge both digits must match.
  task automatic test_cascade();
    int expC;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk) begin cEn = 1'b1; cUp = 1'b1; end
      expCountQ.push_back((i + 1) % 100);
      @(posedge clk) #1;
      expC = expCountQ.pop_front();
      compared++;
      if (c1Count !== 4'(expC / 10) || c0Count !== 4'(expC % 10)) begin
        mismatched++;
        $display("[TB] FAIL cascade step %0d: got %0d%0d required %0d", i, c1Count, c0Count, expC);
      end
    end
    @(negedge clk) cEn = 1'b0;
  endtask

  // Default 8-bit instance: full lap up, then one step down from 0, then hold.
  task automatic test_defaults();
    int expC;
    bit expO;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk) begin dEn = 1'b1; dUp = 1'b1; end
      expCountQ.push_back((i + 1) % 256); expOvfQ.push_back(i == 255);
      @(posedge clk) #1;
      expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
      compared++;
      if (dCount !== 8'(expC) || dOvf !== expO) begin
        mismatched++;
        $display("[TB] FAIL default_up %0d: got %0d/%b required %0d/%b", i, dCount, dOvf, expC, expO);
      end
    end
    @(negedge clk) dUp = 1'b0;
    expCountQ.push_back(255); expOvfQ.push_back(1'b1);
    @(posedge clk) #1;
    expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
    compared++;
    if (dCount !== 8'(expC) || dOvf !== expO) begin
      mismatched++;
      $display("[TB] FAIL default_down_from_0: got %0d/%b required %0d/%b", dCount, dOvf, expC, expO);
    end
    @(negedge clk) dEn = 1'b0;
    expCountQ.push_back(255); expOvfQ.push_back(1'b1);
    @(posedge clk) #1;
    expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
    compared++;
    if (dCount !== 8'(expC) || dOvf !== expO) begin
      mismatched++;
      $display("[TB] FAIL default_hold: got %0d/%b required %0d/%b", dCount, dOvf, expC, expO);
    end
  endtask

  // Random controls every cycle on the saturating instance against a model.
  task automatic test_back_to_back();
    int cur = 0;
    bit ovfM = 1'b0;
    bit expTc, expCarry;
    int expC;
    bit expO;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk) begin
        sClr  = (i == 0) || ($urandom_range(0, 11) == 0);
        sLoad = ($urandom_range(0, 5) == 0);
        sEn   = ($urandom_range(0, 3) != 0);
        sUp   = 1'($urandom_range(0, 1));
        sVal  = 4'($urandom_range(0, 15));
      end
      #1;
      expTc    = sUp ? (cur == 9) : (cur == 0);
      expCarry = expTc && sEn && !sClr && !sLoad;
      if (i > 0) begin
        compared++;
        if (sTc !== expTc || sCarry !== expCarry) begin
          mismatched++;
          $display("[TB] FAIL b2b_tc_carry %0d: got %b/%b required %b/%b", i, sTc, sCarry, expTc, expCarry);
        end
      end
      if (sClr) begin
        cur = 0; ovfM = 1'b0;
      end else if (sLoad) begin
        cur = (int'(sVal) > 9) ? 9 : int'(sVal);
      end else if (sEn) begin
        if (sUp) begin
          if (cur == 9) ovfM = 1'b1; else cur = cur + 1;
        end else begin
          if (cur == 0) ovfM = 1'b1; else cur = cur - 1;
        end
      end
      expCountQ.push_back(cur); expOvfQ.push_back(ovfM);
      @(posedge clk) #1;
      expC = expCountQ.pop_front(); expO = expOvfQ.pop_front();
      compared++;
      if (sCount !== 4'(expC) || sOvf !== expO) begin
        mismatched++;
        $display("[TB] FAIL b2b_step %0d: got %0d/%b required %0d/%b", i, sCount, sOvf, expC, expO);
      end
    end
    @(negedge clk) {sEn, sClr, sLoad} = '0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_down_saturate();
    test_load_clamp();
    test_cascade();
    test_defaults();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
